// File: rtl/window_sum.sv
`default_nettype none
// ============================================================================
// Module      : window_sum
// Description : Sliding-window sum and truncating mean of the last N accepted
//               samples. Optional peak tracker enabled by WINDOW_SUM_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module window_sum #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int LOGN = 2,
    parameter int OW   = W + LOGN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          flush,
`ifdef WINDOW_SUM_PEAK_EN
    input  logic          peak_clr,
    output logic [OW-1:0] peak,
`endif
    output logic [OW-1:0] sum,
    output logic [W-1:0]  avg,
    output logic          sum_valid
);

    localparam logic [0:0]      c_st_fill  = 1'b0;
    localparam logic [0:0]      c_st_full  = 1'b1;
    localparam logic [LOGN-1:0] c_cnt_last = LOGN'(N - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [LOGN-1:0] r_fill_cnt;
    logic [LOGN-1:0] w_fill_cnt_next;

    logic [W-1:0]    r_hist [N];
    logic [OW-1:0]   r_sum;
    logic [OW-1:0]   w_sum_acc;
    logic [OW-1:0]   w_sum_next;
    logic            w_accept;

    assign w_accept = in_valid & ~flush;

    // The oldest sample is already part of r_sum, so the subtraction never
    // underflows and the maximum N*(2^W-1) fits in OW bits.
    assign w_sum_acc = r_sum + OW'(in_data) - OW'(r_hist[N-1]);

    always_comb begin
        w_sum_next = r_sum;
        if (flush) begin
            w_sum_next = '0;
        end else if (in_valid) begin
            w_sum_next = w_sum_acc;
        end
    end

    // ------------------------------------------------------------------
    // Fill-state machine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_fill;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= w_fill_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Fill-state machine: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_fill_cnt_next = r_fill_cnt;
        if (flush) begin
            w_state_next    = c_st_fill;
            w_fill_cnt_next = '0;
        end else if (w_accept) begin
            case (r_state)
                c_st_fill: begin
                    if (r_fill_cnt == c_cnt_last) begin
                        w_state_next = c_st_full;
                    end else begin
                        w_fill_cnt_next = r_fill_cnt + LOGN'(1);
                    end
                end
                c_st_full: begin
                    w_state_next = c_st_full;
                end
                default: begin
                    w_state_next    = c_st_fill;
                    w_fill_cnt_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fill-state machine: output logic
    // ------------------------------------------------------------------
    always_comb begin
        sum_valid = 1'b0;
        case (r_state)
            c_st_fill: sum_valid = 1'b0;
            c_st_full: sum_valid = 1'b1;
            default:   sum_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // History shift register and running sum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < N; i++) begin
                r_hist[i] <= '0;
            end
            r_sum <= '0;
        end else if (in_valid) begin
            r_hist[0] <= in_data;
            for (int i = 1; i < N; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_sum <= w_sum_acc;
        end
    end

    assign sum = r_sum;
    assign avg = W'(r_sum >> LOGN);

`ifdef WINDOW_SUM_PEAK_EN
    // ------------------------------------------------------------------
    // Peak tracker: follows the largest sum seen while the window is full
    // ------------------------------------------------------------------
    logic [OW-1:0] r_peak;
    logic          w_peak_track;

    assign w_peak_track = (r_state == c_st_full) || (w_state_next == c_st_full);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_peak <= '0;
        end else if (peak_clr) begin
            r_peak <= w_sum_next;
        end else if (w_peak_track && (w_sum_next > r_peak)) begin
            r_peak <= w_sum_next;
        end
    end

    assign peak = r_peak;
`else
    // Without the peak tracker the next-sum value has no consumer.
    logic w_unused_sum_next;
    assign w_unused_sum_next = ^w_sum_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_sum.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_sum
// Description : Self-checking bench for window_sum: directed scenarios plus
//               randomized traffic checked against a queue-based window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_sum;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int LOGN = 2;
    localparam int OW   = W + LOGN;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          flush;
    logic [OW-1:0] sum;
    logic [W-1:0]  avg;
    logic          sum_valid;
`ifdef WINDOW_SUM_PEAK_EN
    logic          peak_clr;
    logic [OW-1:0] peak;
`endif

    window_sum #(.W(W), .N(N), .LOGN(LOGN), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
`ifdef WINDOW_SUM_PEAK_EN
        .peak_clr  (peak_clr),
        .peak      (peak),
`endif
        .sum       (sum),
        .avg       (avg),
        .sum_valid (sum_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the window is just the list of the last N samples.
    int m_win[$];
    int m_sum  = 0;
    int m_peak = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input int d,
                                input logic f, input logic pc);
        if (r || f) begin
            m_win.delete();
            m_sum  = 0;
            m_peak = 0;
        end else begin
            if (v) begin
                m_win.push_front(d);
                if (m_win.size() > N) void'(m_win.pop_back());
            end
            m_sum = 0;
            foreach (m_win[i]) m_sum += m_win[i];
            if (pc) m_peak = m_sum;
            else if (m_win.size() == N && m_sum > m_peak) m_peak = m_sum;
        end
    endtask

    task automatic step(input logic r, input logic v, input int d,
                        input logic f, input logic pc);
        rst      = r;
        in_valid = v;
        in_data  = W'(d);
        flush    = f;
`ifdef WINDOW_SUM_PEAK_EN
        peak_clr = pc;
`endif
        @(posedge clk);
        model_update(r, v, d, f, pc);
        #1;
        check("sum", int'(sum), m_sum);
        check("avg", int'(avg), m_sum / N);
        check("sum_valid", int'(sum_valid), (m_win.size() == N) ? 1 : 0);
`ifdef WINDOW_SUM_PEAK_EN
        check("peak", int'(peak), m_peak);
`endif
    endtask

    initial begin
        int seq_fill[4];
        seq_fill = '{1, 2, 3, 4};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
`ifdef WINDOW_SUM_PEAK_EN
        peak_clr = 1'b0;
`endif
        #2;
        step(1, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0);
        check("reset_sum", int'(sum), 0);
        check("reset_valid", int'(sum_valid), 0);

        // Fill: 1,2,3,4 -> 1,3,6,10
        for (int i = 0; i < 4; i++) begin
            step(0, 1, seq_fill[i], 0, 0);
            check("fill_valid", int'(sum_valid), (i == 3) ? 1 : 0);
        end
        check("fill_sum", int'(sum), 10);
        check("fill_avg", int'(avg), 2);

        // Slide: 5, idle x3, 6
        step(0, 1, 5, 0, 0);
        check("slide_sum", int'(sum), 14);
        check("slide_avg", int'(avg), 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 11, 0, 0);
            check("idle_sum", int'(sum), 14);
        end
        step(0, 1, 6, 0, 0);
        check("slide2_sum", int'(sum), 18);

        // Maximum: no wrap
        for (int i = 0; i < 8; i++) step(0, 1, 15, 0, 0);
        check("max_sum", int'(sum), 60);
        check("max_avg", int'(avg), 15);

        // Flush colliding with a sample: flush wins
        step(0, 1, 9, 1, 0);
        check("flush_sum", int'(sum), 0);
        check("flush_valid", int'(sum_valid), 0);
        step(0, 1, 2, 0, 0);
        check("post_flush_sum", int'(sum), 2);

        // Reset mid-window
        step(0, 1, 3, 0, 0);
        step(0, 1, 7, 0, 0);
        step(1, 1, 8, 0, 0);
        check("midrst_sum", int'(sum), 0);
        check("midrst_valid", int'(sum_valid), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        check("refill_sum", int'(sum), 4);
        check("refill_valid", int'(sum_valid), 1);

`ifdef WINDOW_SUM_PEAK_EN
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 4, 0, 0);
        check("peak_fill", int'(peak), 16);
        step(0, 1, 0, 0, 0);
        check("peak_hold1", int'(peak), 16);
        check("peak_sum1", int'(sum), 12);
        step(0, 1, 0, 0, 0);
        check("peak_hold2", int'(peak), 16);
        check("peak_sum2", int'(sum), 8);
        step(0, 1, 0, 0, 1);
        check("peak_clr", int'(peak), 4);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 60) == 0, ($urandom % 4) != 0,
                 int'($urandom % (1 << W)), ($urandom % 35) == 0,
                 ($urandom % 40) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
